// File: rtl/prbs_lock_ctrl.sv
// PRBS7 lane-training sequencer: drives the PRBS generator, checks rx words with a
// self-synchronising predictor, then locks, retries or fails. Optional macro: PRBS_LOCK_ERR_INJECT_EN.
module prbs_lock_ctrl #(
    parameter int NBITS      = 8,
    parameter int LAT_CYC    = 16,
    parameter int WIN_LEN    = 256,
    parameter int ERR_THRESH = 0,
    parameter int MAX_TRY    = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             rx_valid_i,
    input  logic [NBITS-1:0] rx_data_i,
`ifdef PRBS_LOCK_ERR_INJECT_EN
    input  logic             err_inject_i,
`endif
    output logic             gen_en_o,
    output logic             gen_clear_o,
    output logic             busy_o,
    output logic             lock_o,
    output logic             fail_o,
    output logic [15:0]      win_err_o,
    output logic [7:0]       try_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam int                WAIT_W    = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAT_CYC - 1);
    localparam int                WIN_W     = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [15:0]       ERR_LIMIT = 16'(ERR_THRESH);
    localparam logic [7:0]        TRY_LIMIT = 8'(MAX_TRY);

    // Only the last 7 bits of the previous word feed the x^7 + x^6 + 1 recurrence.
    function automatic logic [NBITS-1:0] prbs7_predict(input logic [6:0] hist);
        logic [NBITS+6:0] s;
        s = '0;
        s[NBITS+6:NBITS] = hist;
        for (int i = NBITS - 1; i >= 0; i--) begin
            s[i] = s[i+7] ^ s[i+6];
        end
        return s[NBITS-1:0];
    endfunction

    state_t            state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
    logic [WIN_W-1:0]  win_cnt_r, win_nxt_s;
    logic [15:0]       err_cnt_r, err_nxt_s;
    logic [6:0]        hist_r, hist_nxt_s;
    logic              seeded_r, seeded_nxt_s;
    logic [15:0]       win_err_r, win_err_nxt_s;
    logic [7:0]        try_cnt_r, try_nxt_s;
    logic              gen_en_r, gen_en_nxt_s;
    logic              gen_clear_r, gen_clear_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              lock_r, lock_nxt_s;
    logic              fail_r, fail_nxt_s;

    logic              inj_now_s;
    logic [NBITS-1:0]  cmp_word_s;
    logic              mismatch_s;
    logic [15:0]       err_sum_s;
    logic [7:0]        try_inc_s;

`ifdef PRBS_LOCK_ERR_INJECT_EN
    logic inj_d_r;
    logic inj_pend_r;
    logic cmp_fire_s;

    assign cmp_fire_s = ((state_r == ST_CHECK) || (state_r == ST_LOCKED)) && rx_valid_i
                        && seeded_r && !stop_i;
    assign inj_now_s  = inj_pend_r | (err_inject_i & ~inj_d_r);

    // An inject edge stays pending until a compared word consumes it.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            inj_d_r    <= 1'b0;
            inj_pend_r <= 1'b0;
        end else begin
            inj_d_r <= err_inject_i;
            if (cmp_fire_s) begin
                inj_pend_r <= 1'b0;
            end else if (err_inject_i && !inj_d_r) begin
                inj_pend_r <= 1'b1;
            end else begin
                inj_pend_r <= inj_pend_r;
            end
        end
    end
`else
    assign inj_now_s = 1'b0;
`endif

    assign cmp_word_s = rx_data_i ^ {{(NBITS-1){1'b0}}, inj_now_s};
    assign mismatch_s = (cmp_word_s != prbs7_predict(hist_r));
    assign err_sum_s  = (err_cnt_r == 16'hFFFF) ? err_cnt_r : (err_cnt_r + {15'd0, mismatch_s});
    assign try_inc_s  = try_cnt_r + 8'd1;

    // Next-state, window bookkeeping and output decode.
    always_comb begin
        state_nxt_s     = state_r;
        wait_nxt_s      = wait_cnt_r;
        win_nxt_s       = win_cnt_r;
        err_nxt_s       = err_cnt_r;
        hist_nxt_s      = hist_r;
        seeded_nxt_s    = seeded_r;
        win_err_nxt_s   = win_err_r;
        try_nxt_s       = try_cnt_r;
        gen_en_nxt_s    = 1'b0;
        gen_clear_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        lock_nxt_s      = 1'b0;
        fail_nxt_s      = 1'b0;

        if (stop_i) begin
            state_nxt_s  = ST_IDLE;
            wait_nxt_s   = '0;
            win_nxt_s    = '0;
            err_nxt_s    = 16'd0;
            seeded_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FAIL: begin
                    if (start_i) begin
                        state_nxt_s = ST_CLEAR;
                        try_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_CLEAR: begin
                    state_nxt_s = ST_WAIT;
                    wait_nxt_s  = '0;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_nxt_s  = ST_CHECK;
                        wait_nxt_s   = '0;
                        win_nxt_s    = '0;
                        err_nxt_s    = 16'd0;
                        seeded_nxt_s = 1'b0;
                    end else begin
                        wait_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_CHECK, ST_LOCKED: begin
                    if (!rx_valid_i) begin
                        hist_nxt_s = hist_r;
                    end else if (!seeded_r) begin
                        hist_nxt_s   = rx_data_i[6:0];
                        seeded_nxt_s = 1'b1;
                    end else begin
                        hist_nxt_s = rx_data_i[6:0];
                        if (win_cnt_r == WIN_LAST) begin
                            win_nxt_s     = '0;
                            err_nxt_s     = 16'd0;
                            win_err_nxt_s = err_sum_s;
                            if (err_sum_s <= ERR_LIMIT) begin
                                state_nxt_s = ST_LOCKED;
                            end else begin
                                try_nxt_s = try_inc_s;
                                if (try_inc_s == TRY_LIMIT) begin
                                    state_nxt_s = ST_FAIL;
                                end else begin
                                    state_nxt_s = ST_CLEAR;
                                end
                            end
                        end else begin
                            win_nxt_s = win_cnt_r + WIN_W'(1);
                            err_nxt_s = err_sum_s;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        case (state_nxt_s)
            ST_CLEAR: begin
                gen_en_nxt_s    = 1'b1;
                gen_clear_nxt_s = 1'b1;
                busy_nxt_s      = 1'b1;
            end
            ST_WAIT, ST_CHECK: begin
                gen_en_nxt_s = 1'b1;
                busy_nxt_s   = 1'b1;
            end
            ST_LOCKED: begin
                gen_en_nxt_s = 1'b1;
                lock_nxt_s   = 1'b1;
            end
            ST_FAIL: begin
                fail_nxt_s = 1'b1;
            end
            default: begin
                gen_en_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= '0;
            win_cnt_r   <= '0;
            err_cnt_r   <= 16'd0;
            hist_r      <= 7'd0;
            seeded_r    <= 1'b0;
            win_err_r   <= 16'd0;
            try_cnt_r   <= 8'd0;
            gen_en_r    <= 1'b0;
            gen_clear_r <= 1'b0;
            busy_r      <= 1'b0;
            lock_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_nxt_s;
            win_cnt_r   <= win_nxt_s;
            err_cnt_r   <= err_nxt_s;
            hist_r      <= hist_nxt_s;
            seeded_r    <= seeded_nxt_s;
            win_err_r   <= win_err_nxt_s;
            try_cnt_r   <= try_nxt_s;
            gen_en_r    <= gen_en_nxt_s;
            gen_clear_r <= gen_clear_nxt_s;
            busy_r      <= busy_nxt_s;
            lock_r      <= lock_nxt_s;
            fail_r      <= fail_nxt_s;
        end
    end

    assign gen_en_o    = gen_en_r;
    assign gen_clear_o = gen_clear_r;
    assign busy_o      = busy_r;
    assign lock_o      = lock_r;
    assign fail_o      = fail_r;
    assign win_err_o   = win_err_r;
    assign try_cnt_o   = try_cnt_r;

endmodule
